// File: rtl/mips_sim_pkg.sv
// Shared types and defaults for the MIPS simulation harness blocks.
// Holds the run-controller state encoding and its default halt/watchdog settings.
package mips_sim_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      IDLE  = 3'd1,
      RUN   = 3'd2,
      PAUSE = 3'd3,
      STEP  = 3'd4,
      DONE  = 3'd5
   } run_state_t;

   localparam logic [31:0] DEF_HALT_ADDR  = 32'h0000_00FC;
   localparam int          DEF_MAX_CYCLES = 50;

   // States in which the core clock-enable is asserted
   function automatic logic is_enabled_state(input run_state_t s);
      return (s == RUN) || (s == STEP);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-low reset.
// Holds at all ones once reached instead of wrapping.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear dominates, then saturating increment
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + WIDTH'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller for the multicycle MIPS core: reset release, clock-enable,
// free-run / single-step sequencing, cycle and instruction counters, halt and watchdog.
module mips_run_ctrl
   import mips_sim_pkg::*;
#(
   parameter int              RST_CYCLES = 4,
   parameter int              CNT_W      = 32,
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] HALT_ADDR  = PC_W'(DEF_HALT_ADDR),
   parameter int              MAX_CYCLES = DEF_MAX_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             step_mode,
   input  logic             step_req,
   input  logic             instr_done,
   input  logic [PC_W-1:0]  pc,
   output logic             core_rst,
   output logic             core_en,
   output logic             step_ack,
   output logic             done,
   output logic             timeout,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
);

   localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
   localparam logic             WD_ON     = (MAX_CYCLES != 0);
   localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(MAX_CYCLES - 1);

   run_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              core_rst_q, core_rst_d;
   logic              core_en_q, core_en_d;
   logic              step_ack_q, step_ack_d;
   logic              done_q, done_d;
   logic              timeout_q, timeout_d;

   logic              halt_s;
   logic              wd_s;
   logic              cnt_clr_s;
   logic              ins_inc_s;
   logic [CNT_W-1:0]  cycle_cnt_s;
   logic [CNT_W-1:0]  instr_cnt_s;

   assign halt_s    = instr_done && (pc == HALT_ADDR);
   // The watchdog fires on the edge whose increment makes cycle_cnt equal MAX_CYCLES
   assign wd_s      = WD_ON && core_en_q && (cycle_cnt_s == WD_LAST);
   assign cnt_clr_s = (state_q == DONE) && start;
   assign ins_inc_s = instr_done && is_enabled_state(state_q);

   // State, hold counter and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= HOLD;
         hold_cnt_q <= '0;
         core_rst_q <= 1'b0;
         core_en_q  <= 1'b0;
         step_ack_q <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         core_rst_q <= core_rst_d;
         core_en_q  <= core_en_d;
         step_ack_q <= step_ack_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         HOLD: begin
            if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
            else                         state_d = HOLD;
         end
         IDLE: begin
            if (start) state_d = step_mode ? PAUSE : RUN;
            else       state_d = IDLE;
         end
         RUN: begin
            if (halt_s || wd_s)              state_d = DONE;
            else if (instr_done && step_mode) state_d = PAUSE;
            else                             state_d = RUN;
         end
         PAUSE: begin
            if (!step_mode)    state_d = RUN;
            else if (step_req) state_d = STEP;
            else               state_d = PAUSE;
         end
         STEP: begin
            if (halt_s || wd_s)  state_d = DONE;
            else if (instr_done) state_d = PAUSE;
            else                 state_d = STEP;
         end
         DONE: begin
            if (start) state_d = HOLD;
            else       state_d = DONE;
         end
         default: state_d = HOLD;
      endcase
   end

   // Output decode into the next register values; halt beats a same-edge watchdog
   always_comb begin
      hold_cnt_d = '0;
      if (state_q == HOLD) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
      else                 hold_cnt_d = '0;
      core_rst_d = (state_d != HOLD);
      core_en_d  = is_enabled_state(state_d);
      step_ack_d = (state_q == STEP) && instr_done;
      done_d     = (state_d == DONE);
      timeout_d  = (state_d == DONE) &&
                   (timeout_q || (is_enabled_state(state_q) && wd_s && !halt_s));
   end

   sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clr_s),
      .enable (core_en_q),
      .count  (cycle_cnt_s)
   );

   sat_counter #(.WIDTH(CNT_W)) u_instr_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clr_s),
      .enable (ins_inc_s),
      .count  (instr_cnt_s)
   );

   assign core_rst  = core_rst_q;
   assign core_en   = core_en_q;
   assign step_ack  = step_ack_q;
   assign done      = done_q;
   assign timeout   = timeout_q;
   assign cycle_cnt = cycle_cnt_s;
   assign instr_cnt = instr_cnt_s;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Scoreboard bench for mips_run_ctrl: two instances (watchdog 50 and 20) share stimulus.
module tb_mips_run_ctrl;

   localparam logic [31:0] HALT = 32'h0000_00FC;

   logic        clk, rst, start, step_mode, step_req, instr_done;
   logic [31:0] pc;
   logic        a_core_rst, a_core_en, a_step_ack, a_done, a_timeout;
   logic [31:0] a_cycle_cnt, a_instr_cnt;
   logic        b_core_rst, b_core_en, b_step_ack, b_done, b_timeout;
   logic [31:0] b_cycle_cnt, b_instr_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] cyc;
      logic [31:0] ins;
      logic        to;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] ack_q[$];

   mips_run_ctrl #(.RST_CYCLES(4), .CNT_W(32), .PC_W(32), .HALT_ADDR(32'h0000_00FC), .MAX_CYCLES(50)) u_dut_a (
      .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step_req(step_req),
      .instr_done(instr_done), .pc(pc), .core_rst(a_core_rst), .core_en(a_core_en),
      .step_ack(a_step_ack), .done(a_done), .timeout(a_timeout),
      .cycle_cnt(a_cycle_cnt), .instr_cnt(a_instr_cnt)
   );

   mips_run_ctrl #(.RST_CYCLES(4), .CNT_W(32), .PC_W(32), .HALT_ADDR(32'h0000_00FC), .MAX_CYCLES(20)) u_dut_b (
      .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step_req(step_req),
      .instr_done(instr_done), .pc(pc), .core_rst(b_core_rst), .core_en(b_core_en),
      .step_ack(b_step_ack), .done(b_done), .timeout(b_timeout),
      .cycle_cnt(b_cycle_cnt), .instr_cnt(b_instr_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL global_time_limit expired");
      $fatal(1, "time limit");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0; instr_done = 1'b0; pc = 32'h0;
      repeat (2) tick();
      total++;
      if ({a_core_rst, a_core_en, a_step_ack, a_done, a_timeout} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got=%b want=00000", {a_core_rst, a_core_en, a_step_ack, a_done, a_timeout});
      end
      total++;
      if ({a_cycle_cnt, a_instr_cnt} !== 64'h0) begin
         bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", a_cycle_cnt, a_instr_cnt);
      end
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (a_core_rst !== (i == 4)) begin
            bad++; $display("FAIL hold_core_rst edge=%0d got=%b want=%b", i, a_core_rst, (i == 4));
         end
         total++;
         if ({a_core_en, a_step_ack, a_done, a_timeout} !== 4'b0) begin
            bad++; $display("FAIL hold_outputs edge=%0d got=%b want=0000", i, {a_core_en, a_step_ack, a_done, a_timeout});
         end
      end
   endtask

   // DONE -> HOLD via start, then the four-edge reset release
   task automatic restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({a_core_rst, a_done, a_timeout, b_core_rst, b_done, b_timeout} !== 6'b0) begin
         bad++; $display("FAIL restart_flags got=%b want=000000", {a_core_rst, a_done, a_timeout, b_core_rst, b_done, b_timeout});
      end
      total++;
      if ({a_cycle_cnt, a_instr_cnt, b_cycle_cnt, b_instr_cnt} !== 128'h0) begin
         bad++; $display("FAIL restart_counters got=%0d/%0d/%0d/%0d want=0", a_cycle_cnt, a_instr_cnt, b_cycle_cnt, b_instr_cnt);
      end
      repeat (4) tick();
      total++;
      if ({a_core_rst, a_core_en} !== 2'b10) begin
         bad++; $display("FAIL restart_release got=%b want=10", {a_core_rst, a_core_en});
      end
   endtask

   task automatic test_free_run();
      exp_t e;
      step_mode = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (a_core_en !== 1'b1) begin
         bad++; $display("FAIL run_entry got=%b want=1", a_core_en);
      end
      for (int i = 1; i <= 20; i++) begin
         instr_done = ((i % 4) == 0);
         pc = (i == 20) ? HALT : 32'(i * 4);
         if (i == 20) sb_q.push_back('{32'd20, 32'd5, 1'b0});
         tick();
         if (i < 20 && (a_core_en !== 1'b1 || a_done !== 1'b0)) begin
            total++; bad++;
            $display("FAIL free_run_active cycle=%0d got en=%b done=%b want en=1 done=0", i, a_core_en, a_done);
         end
      end
      instr_done = 1'b0;
      e = sb_q.pop_front();
      total++;
      if ({a_done, a_timeout, a_core_en} !== {1'b1, e.to, 1'b0}) begin
         bad++; $display("FAIL free_run_flags got=%b want=%b", {a_done, a_timeout, a_core_en}, {1'b1, e.to, 1'b0});
      end
      total++;
      if (a_cycle_cnt !== e.cyc || a_instr_cnt !== e.ins) begin
         bad++; $display("FAIL free_run_counts got=%0d/%0d want=%0d/%0d", a_cycle_cnt, a_instr_cnt, e.cyc, e.ins);
      end
      tick();
      total++;
      if (a_done !== 1'b1 || a_cycle_cnt !== 32'd20) begin
         bad++; $display("FAIL done_sticky got done=%b cyc=%0d want 1/20", a_done, a_cycle_cnt);
      end
   endtask

   task automatic test_watchdog();
      exp_t e;
      int   en_cycles;
      restart();
      start = 1'b1;
      tick();
      start = 1'b0;
      sb_q.push_back('{32'd50, 32'd0, 1'b1});
      en_cycles = 0;
      for (int n = 0; n < 100; n++) begin
         if (a_done) break;
         if (a_core_en) en_cycles++;
         start = (en_cycles == 10);
         tick();
         start = 1'b0;
      end
      total++;
      if (a_done !== 1'b1) begin
         bad++; $display("FAIL watchdog_wait got done=%b want=1 within budget", a_done);
      end
      e = sb_q.pop_front();
      total++;
      if ({a_timeout, a_core_en} !== {e.to, 1'b0} || a_cycle_cnt !== e.cyc || a_instr_cnt !== e.ins) begin
         bad++; $display("FAIL watchdog_result got to=%b en=%b cyc=%0d ins=%0d want to=%b en=0 cyc=%0d ins=%0d",
                         a_timeout, a_core_en, a_cycle_cnt, a_instr_cnt, e.to, e.cyc, e.ins);
      end
      total++;
      if (en_cycles !== 50) begin
         bad++; $display("FAIL watchdog_enabled_cycles got=%0d want=50", en_cycles);
      end
      total++;
      if ({b_done, b_timeout} !== 2'b11 || b_cycle_cnt !== 32'd20) begin
         bad++; $display("FAIL watchdog_b got done/to=%b cyc=%0d want 11/20", {b_done, b_timeout}, b_cycle_cnt);
      end
   endtask

   task automatic test_single_step();
      logic [31:0] exp_ins;
      restart();
      step_mode = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      instr_done = 1'b1;
      pc = HALT;
      tick();
      instr_done = 1'b0;
      total++;
      if ({a_core_en, a_done} !== 2'b00 || a_instr_cnt !== 32'd0) begin
         bad++; $display("FAIL pause_ignores_retire got en/done=%b ins=%0d want 00/0", {a_core_en, a_done}, a_instr_cnt);
      end
      for (int k = 1; k <= 3; k++) begin
         step_req = 1'b1;
         ack_q.push_back(32'(k));
         tick();
         step_req = 1'b0;
         total++;
         if ({a_core_en, a_step_ack} !== 2'b10) begin
            bad++; $display("FAIL step_entry k=%0d got=%b want=10", k, {a_core_en, a_step_ack});
         end
         tick();
         step_req = 1'b1;
         tick();
         step_req = 1'b0;
         total++;
         if (a_core_en !== 1'b1) begin
            bad++; $display("FAIL step_busy k=%0d got=%b want=1", k, a_core_en);
         end
         instr_done = 1'b1;
         pc = 32'(k * 4);
         tick();
         instr_done = 1'b0;
         exp_ins = ack_q.pop_front();
         total++;
         if ({a_step_ack, a_core_en} !== 2'b10 || a_instr_cnt !== exp_ins) begin
            bad++; $display("FAIL step_ack k=%0d got ack/en=%b ins=%0d want 10/%0d", k, {a_step_ack, a_core_en}, a_instr_cnt, exp_ins);
         end
         tick();
         total++;
         if ({a_step_ack, a_core_en} !== 2'b00) begin
            bad++; $display("FAIL step_gap k=%0d got=%b want=00", k, {a_step_ack, a_core_en});
         end
      end
      total++;
      if (a_cycle_cnt !== 32'd9 || a_instr_cnt !== 32'd3 || a_done !== 1'b0) begin
         bad++; $display("FAIL step_totals got cyc=%0d ins=%0d done=%b want 9/3/0", a_cycle_cnt, a_instr_cnt, a_done);
      end
   endtask

   task automatic test_mid_run_reset();
      step_mode = 1'b0;
      tick();
      total++;
      if (a_core_en !== 1'b1) begin
         bad++; $display("FAIL pause_to_run got=%b want=1", a_core_en);
      end
      repeat (10) tick();
      total++;
      if (a_cycle_cnt !== 32'd19) begin
         bad++; $display("FAIL run_cycles got=%0d want=19", a_cycle_cnt);
      end
      #3;
      rst = 1'b0;
      #1;
      total++;
      if ({a_core_rst, a_core_en, a_step_ack, a_done, a_timeout} !== 5'b0 || {a_cycle_cnt, a_instr_cnt} !== 64'h0) begin
         bad++; $display("FAIL async_reset got=%b cyc=%0d ins=%0d want 00000/0/0",
                         {a_core_rst, a_core_en, a_step_ack, a_done, a_timeout}, a_cycle_cnt, a_instr_cnt);
      end
      tick();
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         total++;
         if (a_core_rst !== (i == 4) || b_core_rst !== (i == 4)) begin
            bad++; $display("FAIL rehold edge=%0d got=%b%b want=%b", i, a_core_rst, b_core_rst, (i == 4));
         end
      end
   endtask

   task automatic test_halt_watchdog();
      exp_t e;
      step_mode = 1'b0;
      instr_done = 1'b1;
      pc = HALT;
      tick();
      instr_done = 1'b0;
      total++;
      if (b_instr_cnt !== 32'd0 || b_done !== 1'b0) begin
         bad++; $display("FAIL idle_ignores_retire got ins=%0d done=%b want 0/0", b_instr_cnt, b_done);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      sb_q.push_back('{32'd20, 32'd1, 1'b0});
      for (int i = 1; i <= 20; i++) begin
         instr_done = (i == 20);
         pc = HALT;
         tick();
      end
      instr_done = 1'b0;
      e = sb_q.pop_front();
      total++;
      if ({b_done, b_timeout, b_core_en} !== {1'b1, e.to, 1'b0}) begin
         bad++; $display("FAIL tie_flags got=%b want=%b", {b_done, b_timeout, b_core_en}, {1'b1, e.to, 1'b0});
      end
      total++;
      if (b_cycle_cnt !== e.cyc || b_instr_cnt !== e.ins || b_step_ack !== 1'b0) begin
         bad++; $display("FAIL tie_counts got=%0d/%0d ack=%b want=%0d/%0d ack=0", b_cycle_cnt, b_instr_cnt, b_step_ack, e.cyc, e.ins);
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if ({b_core_rst, b_done, b_timeout} !== 3'b0 || {b_cycle_cnt, b_instr_cnt} !== 64'h0) begin
         bad++; $display("FAIL tie_restart got=%b cyc=%0d ins=%0d want 000/0/0", {b_core_rst, b_done, b_timeout}, b_cycle_cnt, b_instr_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_watchdog();
      test_single_step();
      test_mid_run_reset();
      test_halt_watchdog();
      total++;
      if (sb_q.size() != 0 || ack_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_leftover got=%0d/%0d want=0/0", sb_q.size(), ack_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mips_run_ctrl.md
# mips_run_ctrl

Parametrised run controller for the multicycle MIPS core. It generates the core's synchronised reset release and a clock-enable, and runs the core either freely or one instruction at a time. It counts cycles and retired instructions, and stops on a halt address or a cycle-budget watchdog. It sits between the top-level `clk`/`rst` and `Mips_machine`, and replaces fixed-length reset/run sequencing with a reusable, parametrised block.

## Interface
Parameters:
- `RST_CYCLES`, 4: rising edges the core reset is held after `rst` deasserts (≥1)
- `CNT_W`, 32: width of the cycle and instruction counters
- `PC_W`, 32: PC width
- `HALT_ADDR`, 32'h0000_00FC: retiring an instruction at this PC ends the run
- `MAX_CYCLES`, 50: enabled-cycle budget; 0 disables the watchdog

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; starts a run from IDLE and restarts from DONE
- `step_mode` in 1: level; 1 selects single-instruction execution
- `step_req` in 1: one-cycle pulse; executes one instruction while PAUSE
- `instr_done` in 1: one-cycle pulse from the core control FSM when an instruction retires
- `pc` in PC_W: PC of the retiring instruction; valid when `instr_done`=1
- `core_rst` out 1: active-low reset to the core
- `core_en` out 1: clock-enable to the core
- `step_ack` out 1: one-cycle pulse when a stepped instruction retires
- `done` out 1: sticky; the run has ended
- `timeout` out 1: sticky; the run ended on the watchdog
- `cycle_cnt` out CNT_W: number of cycles with `core_en`=1
- `instr_cnt` out CNT_W: number of retired instructions

## Operation
- States: HOLD, IDLE, RUN, PAUSE, STEP, DONE.
- `rst`=0 (asynchronous):
  - Forces HOLD and clears the hold counter.
  - Outputs: `core_rst`=0, `core_en`=0, `step_ack`=0, `done`=0, `timeout`=0.
  - Clears `cycle_cnt` and `instr_cnt`.
  - Applies in any state, including mid-run.
- HOLD:
  - `core_rst`=0.
  - The hold counter increments each edge; on the RST_CYCLES-th edge → IDLE and `core_rst`=1.
- IDLE: `core_en`=0. On `start`: → PAUSE if `step_mode`=1, else → RUN.
- RUN:
  - `core_en`=1.
  - `instr_done` with `pc`==HALT_ADDR → DONE.
  - Watchdog expiry → DONE and `timeout`=1.
  - `instr_done` with `step_mode`=1 → PAUSE. RUN→PAUSE happens only on an instruction boundary.
- PAUSE:
  - `core_en`=0.
  - `step_req` → STEP.
  - `step_mode`=0 → RUN; this takes priority over `step_req`.
- STEP:
  - `core_en`=1 until `instr_done`.
  - On `instr_done`: `step_ack` pulses that edge and the state → PAUSE, or → DONE on halt or watchdog.
  - `step_req` is ignored while in STEP.
- DONE:
  - `core_en`=0; `done`=1.
  - `start` → HOLD: the core is re-reset, both counters and both flags are cleared.
- Counters:
  - `cycle_cnt` increments every edge on which `core_en`=1.
  - `instr_cnt` increments on `instr_done` while in RUN or STEP.
  - Both counters saturate at all ones and never wrap.
- Watchdog: expires when `MAX_CYCLES`≠0 and an incrementing `cycle_cnt` reaches `MAX_CYCLES`.
- Halt and watchdog expiring on the same edge: halt wins, `timeout`=0, and `cycle_cnt` still increments.
- `instr_done` outside RUN and STEP is ignored.
- `start` outside IDLE and DONE is ignored.

## Timing
- All outputs are registered and decoded from the state register; there are no combinational input-to-output paths.
- `core_rst` rises exactly RST_CYCLES rising edges after the first edge with `rst`=1.
- Run entry: `start` sampled on edge N gives `core_en`=1 after edge N.
- Run exit: the halt `instr_done` sampled on edge M gives `core_en`=0 and `done`=1 after edge M. The halting instruction is counted.
- Step latency: `step_req` on edge N gives `core_en`=1 from after N until the edge that samples `instr_done`. `step_ack` is high for exactly that one cycle.
- Watchdog: `core_en` falls after the edge where `cycle_cnt` becomes MAX_CYCLES, so exactly MAX_CYCLES enabled cycles occur.

## Structure
- Shared package `mips_sim_pkg`:
  - `run_state_t` enum (HOLD, IDLE, RUN, PAUSE, STEP, DONE).
  - Default constants for `HALT_ADDR` and `MAX_CYCLES`.
- One sub-module, `sat_counter`:
  - Parameter WIDTH; inputs `clk`, `rst`, clear, enable; output count.
  - Saturating; clear is synchronous, reset is asynchronous.
  - Instantiated twice, for cycles and instructions.
- The hold counter is local, `$clog2(RST_CYCLES+1)` bits wide.

## Test plan
1. Reset release, RST_CYCLES=4: `rst` 0→1 → `core_rst` stays 0 for 4 edges and is 1 after the 4th; all other outputs stay 0.
2. Free run: `start` pulse, then `instr_done` every 4 cycles with the 5th at `pc`=HALT_ADDR → `done`=1, `timeout`=0, `instr_cnt`=5, `cycle_cnt`=20, `core_en`=0.
3. Watchdog, MAX_CYCLES=50, `instr_done` never asserted → `timeout`=1, `done`=1, `cycle_cnt`=50 exactly.
4. Single-step, `step_mode`=1: three `step_req` pulses with retire after 3 cycles each → three `step_ack` pulses, `instr_cnt`=3, `cycle_cnt`=9, `core_en`=0 between steps.
5. Mid-run `rst`=0 after 10 cycles in RUN → all outputs 0 immediately and counters 0; after release the HOLD sequence repeats.
6. Halt and watchdog on the same edge (MAX_CYCLES=20, halt `instr_done` on the 20th enabled cycle) → `timeout`=0, `done`=1, `cycle_cnt`=20. Then `start` → HOLD, counters and flags cleared.
